cpu_multicycle_core: RTL and testbench
======================================

Name: cpu_multicycle_core

Overview:
- Parametrised multi-cycle successor to the 19-bit single-cycle CPU top.
- Keeps the 19-bit instruction format and adds a configurable data/address width.
- Uses one shared instruction/data memory port with a ready handshake, so memory can insert wait states.
- Sits between the SoC memory fabric and the debug/trace logic; it raises a halt on an illegal opcode.

Parameters:
- XLEN, 19: register, ALU, PC and memory address/data width; legal range 19..32.
- RESET_PC, 0: PC value loaded on reset; word address.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high.
- mem_req, output, 1: memory request valid; held until mem_ready.
- mem_we, output, 1: 1 = write, 0 = read; valid while mem_req.
- mem_addr, output, XLEN: word address.
- mem_wdata, output, XLEN: store data.
- mem_rdata, input, XLEN: read data; sampled in the cycle mem_req&mem_ready.
- mem_ready, input, 1: transfer completes in any cycle where mem_req&mem_ready.
- pc_out, output, XLEN: address of the current instruction.
- retire, output, 1: one-cycle pulse when an instruction completes.
- halted, output, 1: high in HALT.

Behaviour:
- Reset, when reset is sampled high:
  - state=FETCH, PC=RESET_PC, all 16 registers = 0.
  - mem_req=0, mem_we=0, retire=0, halted=0.
  - Reset aborts any outstanding memory request; mem_req drops in the following cycle.
- Instruction encoding, bits of mem_rdata[18:0], upper bits ignored:
  - op[3:0], rd[7:4], f3[10:8], rs1[14:11], rs2/imm4[18:15].
  - imm11 = [18:8].
  - All immediates are sign-extended to XLEN.
- Register file:
  - 16 x XLEN; r0 reads 0 and writes to it are discarded.
  - Written only in WB.
- FSM: FETCH -> DECODE -> EXEC -> {MEM} -> WB -> FETCH.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - On ready: IR<=rdata[18:0], go to DECODE.
  - Stays in FETCH while ready=0.
- DECODE:
  - A<=R[rs1], B<=R[rs2], D<=R[rd].
  - An opcode not listed below -> HALT.
- EXEC, by opcode; ALU result is wrapped mod 2^XLEN:
  - 0000 ALU, by f3:
    - 000 add, 001 sub, 010 and, 011 or, 100 xor.
    - 101 slt: signed, result 1/0.
    - 110 sll, 111 srl: shift amount = B mod XLEN.
  - 0001 ADDI: A+imm4.
  - 0010 LOAD, 0011 STORE: address = A+imm4.
  - 0100 BEQ: if D==A, PC<=PC+imm4, else PC+1.
  - 0101 JAL: link=PC+1, PC<=PC+imm11.
  - Next state:
    - LOAD/STORE -> MEM.
    - BEQ -> FETCH, with the retire pulse.
    - All others -> WB.
- MEM:
  - mem_req=1, mem_addr=computed address.
  - STORE: mem_we=1, wdata=D (the register named by the rd field).
  - Waits for ready.
  - LOAD: latches rdata and goes to WB.
  - STORE: goes to FETCH with retire.
- WB:
  - R[rd]<=result (ALU result, loaded data, or link).
  - PC<=PC+1 except after JAL.
  - retire=1, next state FETCH.
- PC and branch offsets are word-granular and wrap mod 2^XLEN.
  - BEQ with imm4=0 is a legal self-loop.
- mem_req/mem_we/mem_addr/mem_wdata must stay stable while mem_req=1 and mem_ready=0.
- mem_ready while mem_req=0 is ignored.
- HALT:
  - Terminal state with halted=1 and mem_req=0.
  - PC holds the address of the illegal instruction; exit only by reset.
- Latency with zero-wait memory (mem_ready tied high):
  - ALU/ADDI/JAL: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BEQ: 3 cycles.
  - Each memory wait cycle adds 1.

Test Plan:
- Reset with XLEN=19, RESET_PC=0x10, ready tied 1 -> first request has mem_addr=0x10, mem_we=0; all outputs are 0 during reset.
- Program ADDI r1,r0,-3; ADDI r2,r0,5; ADD r3,r1,r2 -> r3=2, retire pulses 3 times, 12 cycles total; SUB r4,r1,r2 -> 0x7FFF8 (19-bit wrap).
- STORE r2 to [r0+4], then LOAD r5,[r0+4], with mem_ready held low 3 cycles on each access -> write request stable for 4 cycles with wdata=5; r5=5; LOAD takes 8 cycles.
- BEQ r1,r1,imm4=-1 at PC=7 -> next fetch address 6; BEQ with unequal registers -> next fetch address 8; JAL r6,imm11=+20 at PC=3 -> r6=4, next fetch address 23.
- Opcode 1111 fetched at PC=9 -> halted=1 after DECODE, mem_req stays 0, pc_out=9; a later reset clears halted and refetches at RESET_PC.
- Assert reset mid-LOAD while waiting for ready; also run with XLEN=32 and SLL by 31 and 33 (shifts of 31 and 1) -> clean restart at RESET_PC; shift results are correct.

Source files
------------

// File: rtl/cpu_multicycle_core.sv
// Multi-cycle 19-bit-instruction CPU with a configurable datapath width and one
// shared instruction/data memory port that accepts wait states through mem_ready.
module cpu_multicycle_core #(
  parameter int XLEN     = 19,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc_out,
  output logic            retire,
  output logic            halted
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [3:0] OP_ALU   = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_STORE = 4'd3;
  localparam logic [3:0] OP_BEQ   = 4'd4;
  localparam logic [3:0] OP_JAL   = 4'd5;

  localparam logic [XLEN-1:0] RESET_PC_V = XLEN'(RESET_PC);
  localparam logic [XLEN-1:0] XLEN_V     = XLEN'(XLEN);

  state_t          stateReg, stateNext;
  logic [XLEN-1:0] pcReg;
  logic [18:0]     irReg;
  logic [XLEN-1:0] aReg, bReg, dReg;
  logic [XLEN-1:0] resReg, addrReg;
  logic            idleReg;
  logic [XLEN-1:0] rf [16];

  logic [3:0]      op, rd, rs1, rs2;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm4, imm11, pcPlus1, shamt, aluRes;
  logic            isStore, opLegal;

  assign op      = irReg[3:0];
  assign rd      = irReg[7:4];
  assign f3      = irReg[10:8];
  assign rs1     = irReg[14:11];
  assign rs2     = irReg[18:15];
  assign imm4    = {{(XLEN-4){irReg[18]}}, irReg[18:15]};
  assign imm11   = {{(XLEN-11){irReg[18]}}, irReg[18:8]};
  assign pcPlus1 = pcReg + XLEN'(1);
  assign shamt   = bReg % XLEN_V;
  assign isStore = (op == OP_STORE);
  assign opLegal = (op <= OP_JAL);

  assign pc_out    = pcReg;
  assign mem_wdata = dReg;

  always_comb begin
    aluRes = '0;
    case (f3)
      3'd0: aluRes = aReg + bReg;
      3'd1: aluRes = aReg - bReg;
      3'd2: aluRes = aReg & bReg;
      3'd3: aluRes = aReg | bReg;
      3'd4: aluRes = aReg ^ bReg;
      3'd5: aluRes = {{(XLEN-1){1'b0}}, ($signed(aReg) < $signed(bReg))};
      3'd6: aluRes = aReg << shamt;
      default: aluRes = aReg >> shamt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= FETCH;
      idleReg  <= 1'b1;
    end else begin
      stateReg <= stateNext;
      idleReg  <= 1'b0;
    end
  end

  // idleReg keeps the port quiet for the first cycle after reset so a request
  // that was in flight when reset hit is dropped rather than reissued.
  always_comb begin
    stateNext = stateReg;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pcReg;
    retire    = 1'b0;
    halted    = 1'b0;
    case (stateReg)
      FETCH: begin
        mem_req = !idleReg;
        if (!idleReg && mem_ready) stateNext = DECODE;
      end
      DECODE: stateNext = opLegal ? EXEC : HALT;
      EXEC: begin
        if (op == OP_LOAD || op == OP_STORE) begin
          stateNext = MEM;
        end else if (op == OP_BEQ) begin
          stateNext = FETCH;
          retire    = 1'b1;
        end else begin
          stateNext = WB;
        end
      end
      MEM: begin
        mem_req  = 1'b1;
        mem_we   = isStore;
        mem_addr = addrReg;
        if (mem_ready) begin
          stateNext = isStore ? FETCH : WB;
          retire    = isStore;
        end
      end
      WB: begin
        retire    = 1'b1;
        stateNext = FETCH;
      end
      HALT: halted = 1'b1;
      default: stateNext = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcReg   <= RESET_PC_V;
      irReg   <= '0;
      aReg    <= '0;
      bReg    <= '0;
      dReg    <= '0;
      resReg  <= '0;
      addrReg <= '0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      case (stateReg)
        FETCH: if (!idleReg && mem_ready) irReg <= mem_rdata[18:0];
        DECODE: begin
          aReg <= rf[rs1];
          bReg <= rf[rs2];
          dReg <= rf[rd];
        end
        EXEC: begin
          case (op)
            OP_ALU:   resReg  <= aluRes;
            OP_ADDI:  resReg  <= aReg + imm4;
            OP_LOAD,
            OP_STORE: addrReg <= aReg + imm4;
            OP_BEQ:   pcReg   <= (dReg == aReg) ? pcReg + imm4 : pcPlus1;
            OP_JAL: begin
              resReg <= pcPlus1;
              pcReg  <= pcReg + imm11;
            end
            default: resReg <= resReg;
          endcase
        end
        MEM: begin
          if (mem_ready) begin
            if (isStore) pcReg  <= pcPlus1;
            else         resReg <= mem_rdata;
          end
        end
        WB: begin
          // r0 is never written, so reads of it stay zero without a read-side mux
          if (rd != 4'd0) rf[rd] <= resReg;
          if (op != OP_JAL) pcReg <= pcPlus1;
        end
        default: pcReg <= pcReg;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_multicycle_core.sv
// Directed bench: a 19-bit core with a wait-state memory model and a 32-bit core
// with a zero-wait memory, each running small hand-assembled programs.
module tb_cpu_multicycle_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 19-bit core, RESET_PC = 0x10
  logic        rst1 = 1'b1;
  logic        mem1_req, mem1_we, mem1_ready, retire1, halted1;
  logic [18:0] mem1_addr, mem1_wdata, mem1_rdata, pc1;
  logic [18:0] mem1 [256];
  int          waitData = 0;
  int          waitCnt1 = 0;
  logic        tbWe1 = 1'b0, tbClr1 = 1'b0;
  logic [7:0]  tbAddr1 = '0;
  logic [18:0] tbData1 = '0;

  cpu_multicycle_core #(.XLEN(19), .RESET_PC(16)) dut1 (
    .clk(clk), .reset(rst1),
    .mem_req(mem1_req), .mem_we(mem1_we), .mem_addr(mem1_addr),
    .mem_wdata(mem1_wdata), .mem_rdata(mem1_rdata), .mem_ready(mem1_ready),
    .pc_out(pc1), .retire(retire1), .halted(halted1)
  );

  // data addresses (below 0x10) see waitData wait cycles; code is zero-wait
  assign mem1_ready = (mem1_addr < 19'd16) ? (waitCnt1 >= waitData) : 1'b1;
  assign mem1_rdata = mem1[mem1_addr[7:0]];

  always @(posedge clk) begin
    if (tbClr1) begin
      for (int i = 0; i < 256; i++) mem1[i] <= '0;
    end else if (tbWe1) begin
      mem1[tbAddr1] <= tbData1;
    end else if (mem1_req && mem1_ready && mem1_we) begin
      mem1[mem1_addr[7:0]] <= mem1_wdata;
      $display("store core19 addr=%0h data=%0h", mem1_addr, mem1_wdata);
    end
    if (mem1_req && !mem1_ready) waitCnt1 <= waitCnt1 + 1;
    else                         waitCnt1 <= 0;
  end

  // 32-bit core, RESET_PC = 0, memory always ready
  logic        rst2 = 1'b1;
  logic        mem2_req, mem2_we, retire2, halted2;
  logic [31:0] mem2_addr, mem2_wdata, mem2_rdata, pc2;
  logic        mem2_ready;
  logic [31:0] mem2 [64];
  logic        tbWe2 = 1'b0;
  logic [5:0]  tbAddr2 = '0;
  logic [31:0] tbData2 = '0;

  cpu_multicycle_core #(.XLEN(32), .RESET_PC(0)) dut2 (
    .clk(clk), .reset(rst2),
    .mem_req(mem2_req), .mem_we(mem2_we), .mem_addr(mem2_addr),
    .mem_wdata(mem2_wdata), .mem_rdata(mem2_rdata), .mem_ready(mem2_ready),
    .pc_out(pc2), .retire(retire2), .halted(halted2)
  );

  assign mem2_ready = 1'b1;
  assign mem2_rdata = mem2[mem2_addr[5:0]];

  always @(posedge clk) begin
    if (tbWe2) begin
      mem2[tbAddr2] <= tbData2;
    end else if (mem2_req && mem2_ready && mem2_we) begin
      mem2[mem2_addr[5:0]] <= mem2_wdata;
      $display("store core32 addr=%0h data=%0h", mem2_addr, mem2_wdata);
    end
  end

  function automatic logic [18:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [2:0] f3, input logic [3:0] rs1,
                                      input logic [3:0] rs2);
    return {rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [18:0] encJ(input logic [3:0] rd, input logic [10:0] imm);
    return {imm, rd, 4'd5};
  endfunction

  task automatic poke1(input logic [7:0] a, input logic [18:0] d);
    tbAddr1 = a; tbData1 = d; tbWe1 = 1'b1;
    @(negedge clk);
    tbWe1 = 1'b0;
  endtask

  task automatic clear1();
    rst1 = 1'b1; tbClr1 = 1'b1;
    @(negedge clk);
    tbClr1 = 1'b0;
  endtask

  task automatic poke2(input logic [5:0] a, input logic [18:0] d);
    tbAddr2 = a; tbData2 = {13'd0, d}; tbWe2 = 1'b1;
    @(negedge clk);
    tbWe2 = 1'b0;
  endtask

  // leaves the bench at the negedge of the first fetch cycle
  task automatic start1();
    rst1 = 1'b1;
    @(negedge clk); @(negedge clk);
    rst1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    waitData = 0;
    clear1();
    poke1(8'h10, enc(4'd4, 4'd0, 3'd0, 4'd0, 4'd0));
    @(negedge clk);
    total++; if (mem1_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", mem1_req); end
    total++; if (mem1_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", mem1_we); end
    total++; if (retire1 !== 1'b0) begin bad++; $display("FAIL rst_retire got=%b exp=0", retire1); end
    total++; if (halted1 !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", halted1); end
    total++; if (pc1 !== 19'h10) begin bad++; $display("FAIL rst_pc got=%0h exp=10", pc1); end
    rst1 = 1'b0;
    @(negedge clk);
    total++;
    if (mem1_req !== 1'b1 || mem1_addr !== 19'h10 || mem1_we !== 1'b0) begin
      bad++; $display("FAIL first_fetch got req=%b addr=%0h we=%b exp req=1 addr=10 we=0",
                      mem1_req, mem1_addr, mem1_we);
    end
    $display("test_reset done");
  endtask

  task automatic test_alu();
    int cyc;
    int rcyc[$];
    waitData = 0;
    clear1();
    poke1(8'h10, enc(4'd1, 4'd1, 3'd0, 4'd0, 4'hD));  // ADDI r1,r0,-3
    poke1(8'h11, enc(4'd1, 4'd2, 3'd0, 4'd0, 4'd5));  // ADDI r2,r0,5
    poke1(8'h12, enc(4'd0, 4'd3, 3'd0, 4'd1, 4'd2));  // ADD  r3,r1,r2
    poke1(8'h13, enc(4'd0, 4'd4, 3'd1, 4'd1, 4'd2));  // SUB  r4,r1,r2
    poke1(8'h14, enc(4'd0, 4'd7, 3'd2, 4'd1, 4'd2));  // AND  r7,r1,r2
    poke1(8'h15, enc(4'd0, 4'd8, 3'd3, 4'd1, 4'd2));  // OR   r8,r1,r2
    poke1(8'h16, enc(4'd3, 4'd3, 3'd0, 4'd0, 4'd1));  // STORE r3,[r0+1]
    poke1(8'h17, enc(4'd3, 4'd4, 3'd0, 4'd0, 4'd2));
    poke1(8'h18, enc(4'd3, 4'd7, 3'd0, 4'd0, 4'd3));
    poke1(8'h19, enc(4'd3, 4'd8, 3'd0, 4'd0, 4'd4));
    poke1(8'h1A, enc(4'd4, 4'd0, 3'd0, 4'd0, 4'd0));  // BEQ r0,r0,0
    start1();
    cyc = 1;
    while (cyc <= 50) begin
      if (retire1) rcyc.push_back(cyc);
      @(negedge clk);
      cyc++;
    end
    total++;
    if (rcyc.size() < 10) begin
      bad++; $display("FAIL alu_retire_count got=%0d exp>=10", rcyc.size());
    end else begin
      total++; if (rcyc[0] != 4) begin bad++; $display("FAIL alu_first_retire got=%0d exp=4", rcyc[0]); end
      total++; if (rcyc[2] != 12) begin bad++; $display("FAIL alu_three_instr got=%0d exp=12", rcyc[2]); end
      total++; if (rcyc[9] != 40) begin bad++; $display("FAIL alu_tenth_retire got=%0d exp=40", rcyc[9]); end
    end
    total++; if (mem1[1] !== 19'h00002) begin bad++; $display("FAIL alu_add got=%0h exp=2", mem1[1]); end
    total++; if (mem1[2] !== 19'h7FFF8) begin bad++; $display("FAIL alu_sub got=%0h exp=7fff8", mem1[2]); end
    total++; if (mem1[3] !== 19'h00005) begin bad++; $display("FAIL alu_and got=%0h exp=5", mem1[3]); end
    total++; if (mem1[4] !== 19'h7FFFD) begin bad++; $display("FAIL alu_or got=%0h exp=7fffd", mem1[4]); end
    total++; if (pc1 !== 19'h1A) begin bad++; $display("FAIL alu_selfloop_pc got=%0h exp=1a", pc1); end
    $display("test_alu done");
  endtask

  task automatic test_wait_states();
    int cyc, storeCyc, wdBad;
    int rcyc[$];
    clear1();
    poke1(8'h10, enc(4'd1, 4'd2, 3'd0, 4'd0, 4'd5));  // ADDI r2,r0,5
    poke1(8'h11, enc(4'd3, 4'd2, 3'd0, 4'd0, 4'd4));  // STORE r2,[r0+4]
    poke1(8'h12, enc(4'd2, 4'd5, 3'd0, 4'd0, 4'd4));  // LOAD r5,[r0+4]
    poke1(8'h13, enc(4'd3, 4'd5, 3'd0, 4'd0, 4'd5));  // STORE r5,[r0+5]
    poke1(8'h14, enc(4'd4, 4'd0, 3'd0, 4'd0, 4'd0));
    waitData = 3;
    start1();
    cyc = 1; storeCyc = 0; wdBad = 0;
    while (cyc <= 35) begin
      if (retire1) rcyc.push_back(cyc);
      if (mem1_req && mem1_we && mem1_addr == 19'd4) begin
        storeCyc++;
        if (mem1_wdata !== 19'd5) wdBad++;
      end
      @(negedge clk);
      cyc++;
    end
    total++; if (storeCyc != 4) begin bad++; $display("FAIL store_hold_cycles got=%0d exp=4", storeCyc); end
    total++; if (wdBad != 0) begin bad++; $display("FAIL store_wdata_stable got=%0d bad cycles exp=0", wdBad); end
    total++;
    if (rcyc.size() < 4) begin
      bad++; $display("FAIL wait_retire_count got=%0d exp>=4", rcyc.size());
    end else begin
      total++; if (rcyc[1] != 11) begin bad++; $display("FAIL store_latency got=%0d exp=11", rcyc[1]); end
      total++; if (rcyc[2] - rcyc[1] != 8) begin bad++; $display("FAIL load_latency got=%0d exp=8", rcyc[2] - rcyc[1]); end
    end
    total++; if (mem1[4] !== 19'd5) begin bad++; $display("FAIL store_data got=%0h exp=5", mem1[4]); end
    total++; if (mem1[5] !== 19'd5) begin bad++; $display("FAIL load_data got=%0h exp=5", mem1[5]); end
    waitData = 0;
    $display("test_wait_states done");
  endtask

  task automatic test_branch_jal();
    int cyc;
    logic [18:0] fetches[$];
    logic [18:0] expSeq [8];
    expSeq = '{19'h10, 19'h11, 19'h07, 19'h06, 19'h03, 19'h17, 19'h18, 19'h19};
    waitData = 0;
    clear1();
    poke1(8'h10, enc(4'd1, 4'd1, 3'd0, 4'd0, 4'd2));  // ADDI r1,r0,2
    poke1(8'h11, encJ(4'd0, 11'h7F6));                // JAL r0,-10
    poke1(8'h07, enc(4'd4, 4'd1, 3'd0, 4'd1, 4'hF));  // BEQ r1,r1,-1
    poke1(8'h06, encJ(4'd0, 11'h7FD));                // JAL r0,-3
    poke1(8'h03, encJ(4'd6, 11'd20));                 // JAL r6,+20
    poke1(8'h17, enc(4'd3, 4'd6, 3'd0, 4'd0, 4'd1));  // STORE r6,[r0+1]
    poke1(8'h18, enc(4'd4, 4'd1, 3'd0, 4'd0, 4'd5));  // BEQ r1,r0,+5 (not taken)
    poke1(8'h19, enc(4'd4, 4'd0, 3'd0, 4'd0, 4'd0));
    start1();
    cyc = 1;
    while (cyc <= 50) begin
      if (mem1_req && mem1_ready && !mem1_we) fetches.push_back(mem1_addr);
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (i >= fetches.size()) begin
        bad++; $display("FAIL fetch_seq[%0d] got=none exp=%0h", i, expSeq[i]);
      end else if (fetches[i] !== expSeq[i]) begin
        bad++; $display("FAIL fetch_seq[%0d] got=%0h exp=%0h", i, fetches[i], expSeq[i]);
      end
    end
    total++; if (mem1[1] !== 19'd4) begin bad++; $display("FAIL jal_link got=%0h exp=4", mem1[1]); end
    total++; if (pc1 !== 19'h19) begin bad++; $display("FAIL branch_final_pc got=%0h exp=19", pc1); end
    $display("test_branch_jal done");
  endtask

  task automatic test_halt();
    int cyc, hcyc, busy;
    waitData = 0;
    clear1();
    poke1(8'h10, enc(4'd1, 4'd1, 3'd0, 4'd0, 4'd1));  // ADDI r1,r0,1
    poke1(8'h11, encJ(4'd0, 11'h7F8));                // JAL r0,-8 -> 9
    poke1(8'h09, 19'h0000F);                          // illegal opcode
    start1();
    cyc = 1; hcyc = 0;
    while (cyc <= 30 && hcyc == 0) begin
      if (halted1) hcyc = cyc;
      else begin @(negedge clk); cyc++; end
    end
    total++; if (hcyc != 11) begin bad++; $display("FAIL halt_cycle got=%0d exp=11", hcyc); end
    total++; if (pc1 !== 19'd9) begin bad++; $display("FAIL halt_pc got=%0h exp=9", pc1); end
    busy = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem1_req || retire1 || !halted1) busy++;
    end
    total++; if (busy != 0) begin bad++; $display("FAIL halt_quiet got=%0d busy cycles exp=0", busy); end
    rst1 = 1'b1;
    @(negedge clk);
    total++; if (halted1 !== 1'b0) begin bad++; $display("FAIL halt_cleared got=%b exp=0", halted1); end
    rst1 = 1'b0;
    @(negedge clk);
    total++;
    if (mem1_req !== 1'b1 || mem1_addr !== 19'h10) begin
      bad++; $display("FAIL halt_refetch got req=%b addr=%0h exp req=1 addr=10", mem1_req, mem1_addr);
    end
    $display("test_halt done");
  endtask

  task automatic test_reset_mid_load();
    clear1();
    poke1(8'h04, 19'h01234);
    poke1(8'h10, enc(4'd2, 4'd5, 3'd0, 4'd0, 4'd4));  // LOAD r5,[r0+4]
    poke1(8'h11, enc(4'd3, 4'd5, 3'd0, 4'd0, 4'd5));  // STORE r5,[r0+5]
    poke1(8'h12, enc(4'd4, 4'd0, 3'd0, 4'd0, 4'd0));
    waitData = 20;
    start1();
    repeat (5) @(negedge clk);
    total++;
    if (mem1_req !== 1'b1 || mem1_we !== 1'b0 || mem1_addr !== 19'd4) begin
      bad++; $display("FAIL midload_pending got req=%b we=%b addr=%0h exp req=1 we=0 addr=4",
                      mem1_req, mem1_we, mem1_addr);
    end
    rst1 = 1'b1;
    @(negedge clk);
    total++; if (mem1_req !== 1'b0) begin bad++; $display("FAIL midload_abort got=%b exp=0", mem1_req); end
    waitData = 0;
    rst1 = 1'b0;
    @(negedge clk);
    total++;
    if (mem1_req !== 1'b1 || mem1_addr !== 19'h10 || mem1_we !== 1'b0) begin
      bad++; $display("FAIL midload_restart got req=%b addr=%0h exp req=1 addr=10", mem1_req, mem1_addr);
    end
    repeat (20) @(negedge clk);
    total++; if (mem1[5] !== 19'h01234) begin bad++; $display("FAIL midload_rerun got=%0h exp=1234", mem1[5]); end
    $display("test_reset_mid_load done");
  endtask

  task automatic test_shift32();
    rst2 = 1'b1;
    for (int i = 0; i < 64; i++) poke2(6'(i), 19'd0);
    poke2(6'd0,  enc(4'd1, 4'd1, 3'd0, 4'd0, 4'd3));  // ADDI r1,r0,3
    poke2(6'd1,  enc(4'd1, 4'd2, 3'd0, 4'd0, 4'd7));  // ADDI r2,r0,7
    poke2(6'd2,  enc(4'd0, 4'd3, 3'd0, 4'd2, 4'd2));  // r3=14
    poke2(6'd3,  enc(4'd0, 4'd3, 3'd0, 4'd3, 4'd3));  // r3=28
    poke2(6'd4,  enc(4'd1, 4'd3, 3'd0, 4'd3, 4'd3));  // r3=31
    poke2(6'd5,  enc(4'd1, 4'd4, 3'd0, 4'd3, 4'd2));  // r4=33
    poke2(6'd6,  enc(4'd0, 4'd5, 3'd6, 4'd1, 4'd3));  // SLL r5,r1,r3
    poke2(6'd7,  enc(4'd0, 4'd6, 3'd6, 4'd1, 4'd4));  // SLL r6,r1,r4
    poke2(6'd8,  enc(4'd0, 4'd7, 3'd7, 4'd5, 4'd3));  // SRL r7,r5,r3
    poke2(6'd9,  enc(4'd0, 4'd9, 3'd5, 4'd5, 4'd1));  // SLT r9,r5,r1
    poke2(6'd10, enc(4'd3, 4'd5, 3'd0, 4'd3, 4'd0));
    poke2(6'd11, enc(4'd3, 4'd6, 3'd0, 4'd3, 4'd1));
    poke2(6'd12, enc(4'd3, 4'd7, 3'd0, 4'd3, 4'd2));
    poke2(6'd13, enc(4'd3, 4'd9, 3'd0, 4'd3, 4'd3));
    poke2(6'd14, enc(4'd4, 4'd0, 3'd0, 4'd0, 4'd0));
    rst2 = 1'b0;
    @(negedge clk);
    total++;
    if (mem2_req !== 1'b1 || mem2_addr !== 32'd0) begin
      bad++; $display("FAIL x32_first_fetch got req=%b addr=%0h exp req=1 addr=0", mem2_req, mem2_addr);
    end
    repeat (80) @(negedge clk);
    total++; if (mem2[31] !== 32'h80000000) begin bad++; $display("FAIL x32_sll31 got=%0h exp=80000000", mem2[31]); end
    total++; if (mem2[32] !== 32'd6) begin bad++; $display("FAIL x32_sll33 got=%0h exp=6", mem2[32]); end
    total++; if (mem2[33] !== 32'd1) begin bad++; $display("FAIL x32_srl31 got=%0h exp=1", mem2[33]); end
    total++; if (mem2[34] !== 32'd1) begin bad++; $display("FAIL x32_slt got=%0h exp=1", mem2[34]); end
    $display("test_shift32 done");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_wait_states();
    test_branch_jal();
    test_halt();
    test_reset_mid_load();
    test_shift32();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
